// File: rtl/axis_width_upsizer.sv
// axis_width_upsizer: packs RATIO consecutive DATA_SIZE-bit AXIS beats into one registered wide beat.
// Optional packet end/keep support when AXIS_UPSIZER_TLAST_EN is defined.
module axis_width_upsizer #(
    parameter int DATA_SIZE = 8,
    parameter int RATIO     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef AXIS_UPSIZER_TLAST_EN
    input  logic                       s_last,
    output logic                       m_last,
    output logic [RATIO-1:0]           m_keep,
`endif
    input  logic [DATA_SIZE-1:0]       s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_SIZE*RATIO-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready
);
    localparam int W  = DATA_SIZE*RATIO;
    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO-1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-DATA_SIZE-1:0] acc_q, acc_d;
    logic [W-1:0]           word_d;
    logic                   pending, accept, complete;

`ifdef AXIS_UPSIZER_TLAST_EN
    logic [W-1:0]     ext;
    logic [RATIO-1:0] keep_d;
    assign pending = cnt_q == LAST || s_last;
    assign ext = W'(acc_q);
    // Lanes past the completing one are zeroed so stale accumulator data never leaks out.
    always_comb begin
        word_d = '0;
        keep_d = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (CW'(l) == cnt_q)
                word_d[l*DATA_SIZE +: DATA_SIZE] = s_data;
            else if (CW'(l) < cnt_q)
                word_d[l*DATA_SIZE +: DATA_SIZE] = ext[l*DATA_SIZE +: DATA_SIZE];
            keep_d[l] = CW'(l) <= cnt_q;
        end
    end
`else
    assign pending = cnt_q == LAST;
    assign word_d  = {s_data, acc_q};
`endif

    assign s_ready  = !(pending && m_valid && !m_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && pending;

    always_comb begin
        cnt_d = complete ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
        acc_d = acc_q;
        for (int l = 0; l < RATIO-1; l++)
            if (accept && cnt_q == CW'(l)) acc_d[l*DATA_SIZE +: DATA_SIZE] = s_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
`ifdef AXIS_UPSIZER_TLAST_EN
            m_last  <= 1'b0;
            m_keep  <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            if (complete) begin
                m_data  <= word_d;
                m_valid <= 1'b1;
`ifdef AXIS_UPSIZER_TLAST_EN
                m_last  <= s_last;
                m_keep  <= keep_d;
`endif
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_width_upsizer.sv
// tb_axis_width_upsizer: directed vectors for the 8-bit x4 upsizer, expected words computed by hand.
module tb_axis_width_upsizer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        s_last = 1'b0;
`ifdef AXIS_UPSIZER_TLAST_EN
    logic        m_last;
    logic [3:0]  m_keep;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_width_upsizer #(.DATA_SIZE(8), .RATIO(4)) dut (
        .clk(clk),
        .reset(reset),
`ifdef AXIS_UPSIZER_TLAST_EN
        .s_last(s_last),
        .m_last(m_last),
        .m_keep(m_keep),
`endif
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, check s_ready before the edge, then clock it in.
    task automatic beat(input logic [7:0] d, input logic last, input logic exp_rdy, input string tag);
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(s_ready), 32'(exp_rdy));
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(m_valid), 32'h0);
        chk("rst_data", m_data, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(s_ready), 32'h1);

        // Basic pack
        beat(8'h11, 1'b0, 1'b1, "b0");
        beat(8'h22, 1'b0, 1'b1, "b1");
        beat(8'h33, 1'b0, 1'b1, "b2");
        chk("basic_nvalid", 32'(m_valid), 32'h0);
        beat(8'h44, 1'b0, 1'b1, "b3");
        chk("basic_valid", 32'(m_valid), 32'h1);
        chk("basic_data", m_data, 32'h44332211);

        // Continuous stream 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            beat(8'(i), 1'b0, 1'b1, "str");
            chk("str_valid", 32'(m_valid), 32'((i % 4) == 3));
            if (i % 4 == 3)
                chk("str_data", m_data, {8'(i), 8'(i-1), 8'(i-2), 8'(i-3)});
        end

        // Back-pressure: word 0x0F0E0D0C held, absorb three beats, stall the fourth
        m_ready = 1'b0;
        beat(8'h05, 1'b0, 1'b1, "bp5");
        beat(8'h06, 1'b0, 1'b1, "bp6");
        beat(8'h07, 1'b0, 1'b1, "bp7");
        s_valid = 1'b0;
        #1;
        chk("bp_rdy_novalid", 32'(s_ready), 32'h0);
        beat(8'h08, 1'b0, 1'b0, "bp8_stall");
        chk("bp_hold_data", m_data, 32'h0F0E0D0C);
        chk("bp_hold_valid", 32'(m_valid), 32'h1);
        m_ready = 1'b1;
        beat(8'h08, 1'b0, 1'b1, "bp8_go");
        chk("bp_new_valid", 32'(m_valid), 32'h1);
        chk("bp_new_data", m_data, 32'h08070605);
        m_ready = 1'b0;
        step();
        chk("bp_held2", m_data, 32'h08070605);
        m_ready = 1'b1;
        step();
        chk("bp_drained", 32'(m_valid), 32'h0);

        // Reset mid-word discards the partial packing
        beat(8'hAA, 1'b0, 1'b1, "rA");
        beat(8'hBB, 1'b0, 1'b1, "rB");
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("after_rst_valid", 32'(m_valid), 32'h0);
        beat(8'h01, 1'b0, 1'b1, "r1");
        beat(8'h02, 1'b0, 1'b1, "r2");
        beat(8'h03, 1'b0, 1'b1, "r3");
        chk("r_nvalid", 32'(m_valid), 32'h0);
        beat(8'h04, 1'b0, 1'b1, "r4");
        chk("r_valid", 32'(m_valid), 32'h1);
        chk("r_data", m_data, 32'h04030201);

`ifdef AXIS_UPSIZER_TLAST_EN
        beat(8'h10, 1'b0, 1'b1, "l0");
        beat(8'h20, 1'b1, 1'b1, "l1");
        chk("l_short_valid", 32'(m_valid), 32'h1);
        chk("l_short_data", m_data, 32'h00002010);
        chk("l_short_keep", 32'(m_keep), 32'h3);
        chk("l_short_last", 32'(m_last), 32'h1);
        for (int i = 0; i < 4; i++) beat(8'h30 + 8'(i), 1'b0, 1'b1, "lf");
        chk("l_full_data", m_data, 32'h33323130);
        chk("l_full_keep", 32'(m_keep), 32'hF);
        chk("l_full_last", 32'(m_last), 32'h0);
        beat(8'h7F, 1'b1, 1'b1, "l1b");
        chk("l_one_data", m_data, 32'h0000007F);
        chk("l_one_keep", 32'(m_keep), 32'h1);
        chk("l_one_last", 32'(m_last), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
